// File: rtl/proc_pkg.sv
// Shared types and constants for the program launch sequencer.
package proc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    LAUNCH   = 3'd2,
    RUN      = 3'd3,
    FINISHED = 3'd4
  } launch_state_t;

  localparam int PROG_IDX_W = 2;

  localparam int DEF_BASE0 = 0;
  localparam int DEF_BASE1 = 100;
  localparam int DEF_BASE2 = 200;
  localparam int DEF_BASE3 = 300;

endpackage

// File: rtl/edge_det.sv
// Registers Start once and reports single-cycle rise/fall strobes.
module edge_det (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Rise,
  output logic Fall
);

  logic start_r;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      start_r <= 1'b0;
    end else begin
      start_r <= Start;
    end
  end

  assign Rise = Start & ~start_r;
  assign Fall = ~Start & start_r;

endmodule

// File: rtl/prog_launch_ctrl.sv
// Program launch sequencer: Start/Done handshake, program selection, PC load and core hold.
// Optional macro PROG_LAUNCH_CYCLE_COUNT_EN adds a saturating RUN-cycle counter output.
//
// Handshake: a Start rise arms the block (from IDLE or FINISHED); the following
// Start fall launches the next program with a one-cycle PcLoad. Done is a level,
// looked at only in RUN; Ack is a level held from FINISHED until the next rise.
module prog_launch_ctrl
  import proc_pkg::*;
#(
  parameter int A         = 10,
  parameter int NUM_PROGS = 3,
  parameter int BASE0     = DEF_BASE0,
  parameter int BASE1     = DEF_BASE1,
  parameter int BASE2     = DEF_BASE2,
  parameter int BASE3     = DEF_BASE3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Done,
  output logic                  PcLoad,
  output logic [A-1:0]          PcTarget,
  output logic                  CoreHold,
  output logic [PROG_IDX_W-1:0] ProgIndex,
  output logic                  Ack,
  output launch_state_t         DbgState
`ifdef PROG_LAUNCH_CYCLE_COUNT_EN
  ,
  output logic [31:0]           CycleCount
`endif
);

  localparam logic [PROG_IDX_W-1:0] LAST_IDX = PROG_IDX_W'(NUM_PROGS - 1);
  localparam logic [A-1:0]          B0       = A'(BASE0);
  localparam logic [A-1:0]          B1       = A'(BASE1);
  localparam logic [A-1:0]          B2       = A'(BASE2);
  localparam logic [A-1:0]          B3       = A'(BASE3);

  launch_state_t           state;
  launch_state_t           state_nxt;
  logic [PROG_IDX_W-1:0]   pending;
  logic                    rise;
  logic                    fall;

  function automatic logic [A-1:0] base_of(input logic [PROG_IDX_W-1:0] idx);
    case (idx)
      2'd0:    return B0;
      2'd1:    return B1;
      2'd2:    return B2;
      default: return B3;
    endcase
  endfunction

  edge_det u_edge_det (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Rise  (rise),
    .Fall  (fall)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      pending   <= '0;
      ProgIndex <= '0;
      PcTarget  <= B0;
    end else begin
      state <= state_nxt;
      if (state == ARMED && fall) begin
        ProgIndex <= pending;
        PcTarget  <= base_of(pending);
      end
      // Pending advances as the launch is issued, so the next round picks the next program.
      if (state == LAUNCH) begin
        pending <= (pending == LAST_IDX) ? '0 : pending + PROG_IDX_W'(1);
      end
    end
  end

  // Outputs depend on the registered state only; Start/Done reach them solely through state.
  always_comb begin
    state_nxt = state;
    PcLoad    = 1'b0;
    CoreHold  = 1'b1;
    Ack       = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = ARMED;
      end
      ARMED: begin
        if (fall) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        PcLoad    = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        CoreHold = 1'b0;
        if (Done) state_nxt = FINISHED;
      end
      FINISHED: begin
        Ack = 1'b1;
        if (rise) state_nxt = ARMED;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign DbgState = state;

`ifdef PROG_LAUNCH_CYCLE_COUNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      CycleCount <= '0;
    end else if (state == LAUNCH) begin
      CycleCount <= '0;
    end else if (state == RUN && CycleCount != 32'hFFFF_FFFF) begin
      CycleCount <= CycleCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prog_launch_ctrl.sv
// Self-checking bench for prog_launch_ctrl against a launch-sequence reference model.
module tb_prog_launch_ctrl;
  import proc_pkg::*;

  localparam int A  = 10;
  localparam int NP = 3;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  logic Start;
  logic Done;
  logic            PcLoad;
  logic [A-1:0]    PcTarget;
  logic            CoreHold;
  logic [1:0]      ProgIndex;
  logic            Ack;
  launch_state_t   dbg_state;
`ifdef PROG_LAUNCH_CYCLE_COUNT_EN
  logic [31:0]     CycleCount;
`endif

  always #5 Clk = ~Clk;

  prog_launch_ctrl #(
    .A         (A),
    .NUM_PROGS (NP),
    .BASE0     (0),
    .BASE1     (100),
    .BASE2     (200),
    .BASE3     (300)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Done      (Done),
    .PcLoad    (PcLoad),
    .PcTarget  (PcTarget),
    .CoreHold  (CoreHold),
    .ProgIndex (ProgIndex),
    .Ack       (Ack),
    .DbgState  (dbg_state)
`ifdef PROG_LAUNCH_CYCLE_COUNT_EN
    ,
    .CycleCount(CycleCount)
`endif
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [A-1:0] exp_q[$];
  int launches;
  int bases[4] = '{0, 100, 200, 300};

  // Model: the n-th launch since reset runs program n mod NUM_PROGS.
  function automatic int model_idx(input int n);
    return n % NP;
  endfunction

  task automatic push_expected();
    exp_q.push_back(A'(bases[model_idx(launches)]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    Start = 1'b0;
    Done  = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    launches = 0;
    exp_q.delete();
  endtask

  // Start high for hi cycles then low; returns what was seen at the PcLoad cycle.
  task automatic drive_launch(input int hi, output int lat, output logic [A-1:0] tgt,
                              output logic [1:0] idx, output logic hold, output logic ack_armed);
    Start = 1'b1;
    tick();
    ack_armed = Ack;
    repeat (hi - 1) tick();
    Start = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (PcLoad !== 1'b1 && lat < 8);
    tgt  = PcTarget;
    idx  = ProgIndex;
    hold = CoreHold;
  endtask

  // Called at the LAUNCH sample; keeps the core in RUN for n cycles, Done on the last.
  task automatic drive_run(input int n, output int run_errs);
    run_errs = 0;
    tick();
    for (int i = 0; i < n - 1; i++) begin
      if (CoreHold !== 1'b0 || PcLoad !== 1'b0 || Ack !== 1'b0) run_errs++;
      tick();
    end
    if (CoreHold !== 1'b0 || PcLoad !== 1'b0 || Ack !== 1'b0) run_errs++;
    Done = 1'b1;
    tick();
    Done = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    total++; if (PcLoad !== 1'b0)     begin bad++; $display("FAIL reset_pcload: got %0b want 0", PcLoad); end
    total++; if (PcTarget !== '0)     begin bad++; $display("FAIL reset_target: got %0d want 0", PcTarget); end
    total++; if (CoreHold !== 1'b1)   begin bad++; $display("FAIL reset_hold: got %0b want 1", CoreHold); end
    total++; if (Ack !== 1'b0)        begin bad++; $display("FAIL reset_ack: got %0b want 0", Ack); end
    total++; if (ProgIndex !== 2'd0)  begin bad++; $display("FAIL reset_idx: got %0d want 0", ProgIndex); end
    total++; if (dbg_state !== IDLE)  begin bad++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_first_launch();
    int lat; logic [A-1:0] tgt; logic [1:0] idx; logic hold; logic ack_a; int errs;
    logic [A-1:0] exp_t;
    apply_reset();
    push_expected();
    drive_launch(2, lat, tgt, idx, hold, ack_a);
    exp_t = exp_q.pop_front();
    total++; if (lat !== 1)    begin bad++; $display("FAIL first_latency: got %0d want 1", lat); end
    total++; if (tgt !== exp_t) begin bad++; $display("FAIL first_target: got %0d want %0d", tgt, exp_t); end
    total++; if (int'(idx) !== model_idx(launches)) begin bad++; $display("FAIL first_idx: got %0d want %0d", idx, model_idx(launches)); end
    total++; if (hold !== 1'b1) begin bad++; $display("FAIL first_hold_launch: got %0b want 1", hold); end
    launches++;
    tick();
    total++; if (PcLoad !== 1'b0)   begin bad++; $display("FAIL first_pcload_width: got %0b want 0", PcLoad); end
    total++; if (CoreHold !== 1'b0) begin bad++; $display("FAIL first_hold_run: got %0b want 0", CoreHold); end
    Done = 1'b1;
    tick();
    Done = 1'b0;
    errs = 0;
    total++; if (Ack !== 1'b1) begin bad++; $display("FAIL first_ack: got %0b want 1", Ack); end
  endtask

  task automatic test_rounds(input int rounds, input bit random_len);
    int lat; logic [A-1:0] tgt; logic [1:0] idx; logic hold; logic ack_a; int errs;
    int hi; int n; int gap; int ack_errs; logic [A-1:0] exp_t;
    for (int r = 0; r < rounds; r++) begin
      hi  = $urandom_range(1, 4);
      n   = random_len ? $urandom_range(1, 40) : 20;
      gap = $urandom_range(0, 5);
      push_expected();
      drive_launch(hi, lat, tgt, idx, hold, ack_a);
      exp_t = exp_q.pop_front();
      total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL round%0d_ack_clear: got %0b want 0", r, ack_a); end
      total++; if (lat !== 1)      begin bad++; $display("FAIL round%0d_latency: got %0d want 1", r, lat); end
      total++; if (tgt !== exp_t)  begin bad++; $display("FAIL round%0d_target: got %0d want %0d", r, tgt, exp_t); end
      total++; if (int'(idx) !== model_idx(launches)) begin bad++; $display("FAIL round%0d_idx: got %0d want %0d", r, idx, model_idx(launches)); end
      launches++;
      drive_run(n, errs);
      total++; if (errs !== 0)     begin bad++; $display("FAIL round%0d_run: got %0d bad cycles want 0", r, errs); end
      total++; if (Ack !== 1'b1 || CoreHold !== 1'b1) begin bad++; $display("FAIL round%0d_finish: got ack=%0b hold=%0b want 1/1", r, Ack, CoreHold); end
`ifdef PROG_LAUNCH_CYCLE_COUNT_EN
      total++; if (CycleCount !== 32'(n)) begin bad++; $display("FAIL round%0d_count: got %0d want %0d", r, CycleCount, n); end
`endif
      ack_errs = 0;
      for (int g = 0; g < gap; g++) begin
        tick();
        if (Ack !== 1'b1) ack_errs++;
      end
      total++; if (ack_errs !== 0) begin bad++; $display("FAIL round%0d_ack_hold: got %0d drops want 0", r, ack_errs); end
    end
  endtask

  task automatic test_zero_length();
    int lat; logic [A-1:0] tgt; logic [1:0] idx; logic hold; logic ack_a;
    push_expected();
    drive_launch(1, lat, tgt, idx, hold, ack_a);
    void'(exp_q.pop_front());
    launches++;
    Done = 1'b1;
    tick();
    total++; if (CoreHold !== 1'b0 || Ack !== 1'b0) begin bad++; $display("FAIL zero_len_run: got hold=%0b ack=%0b want 0/0", CoreHold, Ack); end
    tick();
    Done = 1'b0;
    total++; if (Ack !== 1'b1) begin bad++; $display("FAIL zero_len_finish: got %0b want 1", Ack); end
  endtask

  task automatic test_start_in_run();
    int lat; logic [A-1:0] tgt; logic [1:0] idx; logic hold; logic ack_a; int errs;
    logic [A-1:0] exp_t;
    push_expected();
    drive_launch(3, lat, tgt, idx, hold, ack_a);
    exp_t = exp_q.pop_front();
    total++; if (tgt !== exp_t) begin bad++; $display("FAIL toggle_target: got %0d want %0d", tgt, exp_t); end
    launches++;
    tick();
    errs = 0;
    for (int i = 0; i < 12; i++) begin
      Start = 1'($urandom_range(0, 1));
      tick();
      if (PcLoad !== 1'b0 || CoreHold !== 1'b0 || Ack !== 1'b0) errs++;
    end
    Start = 1'b0;
    tick();
    if (PcLoad !== 1'b0 || CoreHold !== 1'b0) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL toggle_run: got %0d bad cycles want 0", errs); end
    // Done together with a Start rise: Done wins and the rise is lost.
    Start = 1'b1;
    Done  = 1'b1;
    tick();
    Done = 1'b0;
    total++; if (Ack !== 1'b1) begin bad++; $display("FAIL done_vs_rise: got %0b want 1", Ack); end
    tick();
    tick();
    Start = 1'b0;
    tick();
    tick();
    total++; if (Ack !== 1'b1 || PcLoad !== 1'b0) begin bad++; $display("FAIL lost_rise: got ack=%0b load=%0b want 1/0", Ack, PcLoad); end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [A-1:0] tgt; logic [1:0] idx; logic hold; logic ack_a; int errs;
    logic [A-1:0] exp_t;
    apply_reset();
    push_expected();
    drive_launch(2, lat, tgt, idx, hold, ack_a);
    void'(exp_q.pop_front());
    launches++;
    drive_run(5, errs);
    push_expected();
    drive_launch(2, lat, tgt, idx, hold, ack_a);
    exp_t = exp_q.pop_front();
    total++; if (tgt !== exp_t || idx !== 2'd1) begin bad++; $display("FAIL midrun_prog1: got tgt=%0d idx=%0d want %0d/1", tgt, idx, exp_t); end
    launches++;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    total++; if (CoreHold !== 1'b1 || Ack !== 1'b0) begin bad++; $display("FAIL midrun_reset_out: got hold=%0b ack=%0b want 1/0", CoreHold, Ack); end
    total++; if (ProgIndex !== 2'd0 || PcTarget !== '0 || PcLoad !== 1'b0) begin bad++; $display("FAIL midrun_reset_regs: got idx=%0d tgt=%0d load=%0b want 0/0/0", ProgIndex, PcTarget, PcLoad); end
    Reset = 1'b0;
    launches = 0;
    exp_q.delete();
    push_expected();
    drive_launch(2, lat, tgt, idx, hold, ack_a);
    exp_t = exp_q.pop_front();
    total++; if (lat !== 1 || tgt !== exp_t || idx !== 2'd0) begin bad++; $display("FAIL midrun_relaunch: got lat=%0d tgt=%0d idx=%0d want 1/%0d/0", lat, tgt, idx, exp_t); end
    launches++;
    drive_run(3, errs);
  endtask

  task automatic test_start_low();
    int errs;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Ack !== 1'b1 || CoreHold !== 1'b1 || PcLoad !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL start_low_hold: got %0d bad cycles want 0", errs); end
  endtask

`ifdef PROG_LAUNCH_CYCLE_COUNT_EN
  task automatic test_cycle_count();
    int lat; logic [A-1:0] tgt; logic [1:0] idx; logic hold; logic ack_a; int errs;
    push_expected();
    drive_launch(2, lat, tgt, idx, hold, ack_a);
    void'(exp_q.pop_front());
    launches++;
    drive_run(37, errs);
    total++; if (CycleCount !== 32'd37) begin bad++; $display("FAIL count_37: got %0d want 37", CycleCount); end
    repeat (6) tick();
    total++; if (CycleCount !== 32'd37) begin bad++; $display("FAIL count_held: got %0d want 37", CycleCount); end
    push_expected();
    drive_launch(1, lat, tgt, idx, hold, ack_a);
    void'(exp_q.pop_front());
    launches++;
    tick();
    total++; if (CycleCount !== 32'd0) begin bad++; $display("FAIL count_cleared: got %0d want 0", CycleCount); end
    Done = 1'b1;
    tick();
    Done = 1'b0;
    total++; if (CycleCount !== 32'd1) begin bad++; $display("FAIL count_one: got %0d want 1", CycleCount); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Done  = 1'b0;
    test_reset();
    test_first_launch();
    apply_reset();
    test_rounds(4, 1'b0);
    test_rounds(6, 1'b1);
    test_zero_length();
    test_start_in_run();
    test_start_low();
    test_reset_mid_run();
`ifdef PROG_LAUNCH_CYCLE_COUNT_EN
    test_cycle_count();
`endif
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_launch_ctrl.md
Name: prog_launch_ctrl

Overview:
Upstream sequencer for the program counter.
- Takes the bench Start/Done handshake and decides when the core runs.
- Selects which of the packed programs executes next and issues a one-cycle absolute PC load to that program's base address.
- Freezes the core between programs and acknowledges completion back to the bench.

Parameters:
- A, 10: instruction-address width; must match the PC width.
- NUM_PROGS, 3: number of programs in instruction memory (1..4).
- BASE0, 0: start address of program 0.
- BASE1, 100: start address of program 1.
- BASE2, 200: start address of program 2.
- BASE3, 300: start address of program 3 (unused when NUM_PROGS<4).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  bench request, synchronous to Clk; a high pulse then a low (falling edge) launches the next program.
- Done  in  1  core has executed its halt instruction; level, sampled only in RUN.
- PcLoad  out  1  absolute-jump enable to the PC (drives BranchAbsEn); one cycle wide.
- PcTarget  out  A  base address of the selected program; valid whenever PcLoad=1.
- CoreHold  out  1  1 = freeze PC increment and all architectural writes; PcLoad overrides it.
- ProgIndex  out  2  index of the current/last launched program.
- Ack  out  1  level to bench: current program finished.

Behaviour:
- Reset, checked first and able to act in any state (including mid-RUN):
  - state=IDLE, start_r=0, ProgIndex=0, pending index=0.
  - PcLoad=0, PcTarget=BASE0, CoreHold=1, Ack=0.
  - An in-flight program is abandoned; no Ack is issued.
- Edge detection: start_r is Start delayed by one cycle.
  - rise = Start & ~start_r
  - fall = ~Start & start_r
- IDLE:
  - CoreHold=1, Ack=0.
  - On rise, go to ARMED.
- ARMED:
  - Wait for fall.
  - On fall, latch ProgIndex <= pending index, register PcTarget <= BASE[pending], go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - PcLoad=1, CoreHold=1.
  - Pending index <= pending+1; it wraps to 0 when it equals NUM_PROGS-1.
  - Next state is RUN.
- RUN:
  - CoreHold=0, PcLoad=0.
  - When Done=1, go to FINISHED.
  - rise and fall are ignored in this state; start_r still tracks Start.
- FINISHED:
  - CoreHold=1, Ack=1, and Ack stays high.
  - On rise, clear Ack and go to ARMED.
- Latency: fall sampled at edge n gives PcLoad=1 during cycle n+1. The PC holds BASE from edge n+1. CoreHold drops in cycle n+2.
- Done timing: Done asserted during the LAUNCH cycle is ignored. Done already high on entry to RUN causes an immediate finish (program of length 0).
- Start held low forever: the block stays in IDLE or FINISHED indefinitely; no timeout.
- Simultaneous Done and rise in RUN: Done wins, so the block goes to FINISHED. That rise is not seen in FINISHED; the bench must pulse Start again.
- Output timing: all outputs are registered or decoded from the registered state only; no combinational path from Start or Done to any output.
- Width rule: BASE* parameters are truncated to A bits. Out-of-range BASE values are a configuration error and are not checked.

Optional Feature:
- Macro: PROG_LAUNCH_CYCLE_COUNT_EN.
- When defined:
  - Adds output CycleCount [31:0].
  - CycleCount is cleared in LAUNCH and increments by 1 on every RUN cycle, saturating at 2^32-1.
  - It holds its value in FINISHED/IDLE/ARMED until the next LAUNCH.
  - Reset value 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package proc_pkg holds:
  - launch_state_t enum {IDLE, ARMED, LAUNCH, RUN, FINISHED}, 3-bit encoding.
  - PROG_IDX_W=2.
  - Default program base-address constants, used as the parameter defaults.
- Natural sub-module: edge_det. It registers Start and produces rise/fall, with synchronous reset to 0.

Test Plan:
- Reset, then Start pulse (high 2 cycles, then low):
  - PcLoad=1 for exactly one cycle with PcTarget=0, ProgIndex=0.
  - CoreHold=0 two cycles after the fall is sampled.
- Three full rounds, with Done asserted 20 cycles into each RUN:
  - Targets 0, 100, 200 and ProgIndex 0, 1, 2.
  - Ack high after each Done and low after each subsequent Start rise.
- Fourth round after three programs: PcTarget=0, ProgIndex=0 (wrap).
- Start toggled during RUN: no PcLoad, no state change; Done still gives FINISHED.
- Reset asserted mid-RUN of program 1:
  - Next cycle CoreHold=1, Ack=0, ProgIndex=0.
  - The next Start gives target 0.
- With PROG_LAUNCH_CYCLE_COUNT_EN defined and Done after 37 RUN cycles: CycleCount=37, held through FINISHED, cleared on the next LAUNCH.
